// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: exception codes
// and FSM state encodings.
package exc_ctrl_pkg;

  localparam int EXC_TYPE_LENGTH = 4;

  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_NONE = 4'd0;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_INT  = 4'd1;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_SYS  = 4'd2;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_RI   = 4'd3;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_OV   = 4'd4;
  localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ERET = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_FLUSH  = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

endpackage

// File: rtl/exc_ctrl_prio_sel.sv
// Combinational exception candidate selector: MEM > EXE > ID,
// then masked hardware interrupt at the oldest live PC.
module exc_prio_sel
  import exc_ctrl_pkg::*;
(
  input  logic [EXC_TYPE_LENGTH-1:0] exc_id,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_exe,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_mem,
  input  logic [31:0]                pc_if,
  input  logic [31:0]                pc_id,
  input  logic [31:0]                pc_exe,
  input  logic [31:0]                pc_mem,
  input  logic                       bubble_id,
  input  logic                       bubble_exe,
  input  logic                       bubble_mem,
  input  logic                       hard_int_pending,
  output logic                       valid,
  output logic [EXC_TYPE_LENGTH-1:0] code,
  output logic [31:0]                pc
);

  logic v_id;
  logic v_exe;
  logic v_mem;
  logic [31:0] int_pc;

  assign v_id  = (exc_id  != EXC_TYPE_NONE) && !bubble_id;
  assign v_exe = (exc_exe != EXC_TYPE_NONE) && !bubble_exe;
  assign v_mem = (exc_mem != EXC_TYPE_NONE) && !bubble_mem;

  // interrupts attach to the oldest instruction still in flight
  always_comb begin
    int_pc = pc_if;
    priority case (1'b1)
      !bubble_mem: int_pc = pc_mem;
      !bubble_exe: int_pc = pc_exe;
      !bubble_id:  int_pc = pc_id;
      default:     int_pc = pc_if;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    code  = EXC_TYPE_NONE;
    pc    = 32'h0;
    priority case (1'b1)
      v_mem: begin
        valid = 1'b1;
        code  = exc_mem;
        pc    = pc_mem;
      end
      v_exe: begin
        valid = 1'b1;
        code  = exc_exe;
        pc    = pc_exe;
      end
      v_id: begin
        valid = 1'b1;
        code  = exc_id;
        pc    = pc_id;
      end
      hard_int_pending: begin
        valid = 1'b1;
        code  = EXC_TYPE_INT;
        pc    = int_pc;
      end
      default: begin
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: picks a candidate, presents it to cp0 for one
// cycle, then flushes the pipe and holds the front end while it drains.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_id,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_exe,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_mem,
  input  logic [31:0]                pc_if,
  input  logic [31:0]                pc_id,
  input  logic [31:0]                pc_exe,
  input  logic [31:0]                pc_mem,
  input  logic                       bubble_id,
  input  logic                       bubble_exe,
  input  logic                       bubble_mem,
  input  logic                       hard_int_pending,
  input  logic                       int_signal,
  input  logic                       eret_signal,
  output logic [EXC_TYPE_LENGTH-1:0] exc_type,
  output logic [31:0]                exc_pc,
  output logic [3:0]                 flush,
  output logic                       stall_req,
  output logic                       busy
);

  state_t state;
  state_t next;

  logic [2:0]                 cnt;
  logic [EXC_TYPE_LENGTH-1:0] code_q;
  logic [31:0]                pc_q;

  logic                       cand;
  logic [EXC_TYPE_LENGTH-1:0] cand_code;
  logic [31:0]                cand_pc;

  exc_prio_sel u_sel (
    .exc_id           (exc_id),
    .exc_exe          (exc_exe),
    .exc_mem          (exc_mem),
    .pc_if            (pc_if),
    .pc_id            (pc_id),
    .pc_exe           (pc_exe),
    .pc_mem           (pc_mem),
    .bubble_id        (bubble_id),
    .bubble_exe       (bubble_exe),
    .bubble_mem       (bubble_mem),
    .hard_int_pending (hard_int_pending),
    .valid            (cand),
    .code             (cand_code),
    .pc               (cand_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 3'd0;
      code_q <= EXC_TYPE_NONE;
      pc_q   <= 32'h0;
    end else begin
      if (state == S_IDLE && cand) begin
        code_q <= cand_code;
        pc_q   <= cand_pc;
      end
      if (state == S_FLUSH) begin
        cnt <= 3'(DRAIN_CYCLES);
      end else if (state == S_DRAIN && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   next = cand ? S_COMMIT : S_IDLE;
      S_COMMIT: begin
        // cp0 refusing the exception drops straight back to IDLE
        if (int_signal || eret_signal) next = S_FLUSH;
        else                           next = S_IDLE;
      end
      S_FLUSH:  next = S_DRAIN;
      S_DRAIN:  next = (cnt <= 3'd1) ? S_IDLE : S_DRAIN;
      default:  next = S_IDLE;
    endcase
  end

  always_comb begin
    exc_type  = EXC_TYPE_NONE;
    exc_pc    = 32'h0;
    flush     = 4'b0000;
    stall_req = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
      end
      S_COMMIT: begin
        exc_type  = code_q;
        exc_pc    = pc_q;
        stall_req = 1'b1;
        busy      = 1'b1;
      end
      S_FLUSH: begin
        flush     = 4'b1111;
        stall_req = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN: begin
        stall_req = 1'b1;
        busy      = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: per-cycle vector table on a
// DRAIN_CYCLES=2 instance, hand sequences on a DRAIN_CYCLES=4 one.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  localparam logic [31:0] PC_IF  = 32'h0040_0100;
  localparam logic [31:0] PC_ID  = 32'h0040_0208;
  localparam logic [31:0] PC_EXE = 32'h0040_0010;
  localparam logic [31:0] PC_MEM = 32'h0040_0200;

  typedef logic [EXC_TYPE_LENGTH-1:0] ex_t;

  typedef struct {
    logic        rst;
    ex_t         eid;
    ex_t         eexe;
    ex_t         emem;
    logic [2:0]  bub;
    logic        hint;
    logic        ints;
    logic        erets;
    ex_t         x_type;
    logic [31:0] x_pc;
    logic [3:0]  x_flush;
    logic        x_stall;
    logic        x_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  ex_t  exc_id, exc_exe, exc_mem;
  logic [31:0] pc_if, pc_id, pc_exe, pc_mem;
  logic bubble_id, bubble_exe, bubble_mem;
  logic hard_int_pending, int_signal, eret_signal;

  ex_t         exc_type, exc_type4;
  logic [31:0] exc_pc, exc_pc4;
  logic [3:0]  flush, flush4;
  logic        stall_req, stall4;
  logic        busy, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .exc_id(exc_id), .exc_exe(exc_exe), .exc_mem(exc_mem),
    .pc_if(pc_if), .pc_id(pc_id), .pc_exe(pc_exe), .pc_mem(pc_mem),
    .bubble_id(bubble_id), .bubble_exe(bubble_exe),
    .bubble_mem(bubble_mem), .hard_int_pending(hard_int_pending),
    .int_signal(int_signal), .eret_signal(eret_signal),
    .exc_type(exc_type), .exc_pc(exc_pc), .flush(flush),
    .stall_req(stall_req), .busy(busy)
  );

  exc_ctrl #(.DRAIN_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .exc_id(exc_id), .exc_exe(exc_exe), .exc_mem(exc_mem),
    .pc_if(pc_if), .pc_id(pc_id), .pc_exe(pc_exe), .pc_mem(pc_mem),
    .bubble_id(bubble_id), .bubble_exe(bubble_exe),
    .bubble_mem(bubble_mem), .hard_int_pending(hard_int_pending),
    .int_signal(int_signal), .eret_signal(eret_signal),
    .exc_type(exc_type4), .exc_pc(exc_pc4), .flush(flush4),
    .stall_req(stall4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rst;
    exc_id           = v.eid;
    exc_exe          = v.eexe;
    exc_mem          = v.emem;
    bubble_mem       = v.bub[2];
    bubble_exe       = v.bub[1];
    bubble_id        = v.bub[0];
    hard_int_pending = v.hint;
    int_signal       = v.ints;
    eret_signal      = v.erets;
  endtask

  function automatic vec_t v(
    logic r, ex_t i, ex_t e, ex_t m, logic [2:0] b,
    logic h, logic is, logic es,
    ex_t t, logic [31:0] p, logic [3:0] f, logic s, logic bz);
    vec_t x;
    x.rst = r; x.eid = i; x.eexe = e; x.emem = m; x.bub = b;
    x.hint = h; x.ints = is; x.erets = es;
    x.x_type = t; x.x_pc = p; x.x_flush = f;
    x.x_stall = s; x.x_busy = bz;
    return x;
  endfunction

  localparam ex_t N = EXC_TYPE_NONE;
  localparam ex_t I = EXC_TYPE_INT;
  localparam ex_t S = EXC_TYPE_SYS;
  localparam ex_t R = EXC_TYPE_RI;
  localparam ex_t O = EXC_TYPE_OV;
  localparam ex_t E = EXC_TYPE_ERET;

  vec_t tbl[$];
  int   nb;

  initial begin
    rst = 1'b1;
    pc_if = PC_IF; pc_id = PC_ID; pc_exe = PC_EXE; pc_mem = PC_MEM;
    exc_id = N; exc_exe = N; exc_mem = N;
    bubble_id = 1'b0; bubble_exe = 1'b0; bubble_mem = 1'b0;
    hard_int_pending = 1'b0; int_signal = 1'b0; eret_signal = 1'b0;

    // reset state
    tbl.push_back(v(1, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    // SYS at EXE, accepted: commit, flush, drain x2, idle
    tbl.push_back(v(0, N,S,N, 3'b000, 0,0,0, S, PC_EXE, 4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,1,0, N, 0,      4'hF, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    // RI at ID and OV at MEM: OV wins, RI waits for IDLE
    tbl.push_back(v(0, R,N,O, 3'b000, 0,0,0, O, PC_MEM, 4'h0, 1, 1));
    tbl.push_back(v(0, R,N,N, 3'b000, 0,1,0, N, 0,      4'hF, 1, 1));
    tbl.push_back(v(0, R,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 1, 1));
    tbl.push_back(v(0, R,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 1, 1));
    tbl.push_back(v(0, R,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    tbl.push_back(v(0, R,N,N, 3'b000, 0,0,0, R, PC_ID,  4'h0, 1, 1));
    // refused by cp0: back to IDLE, no flush
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    // OV in a bubble is not a candidate
    tbl.push_back(v(0, N,N,O, 3'b100, 0,0,0, N, 0,      4'h0, 0, 0));
    tbl.push_back(v(0, N,N,O, 3'b100, 0,0,0, N, 0,      4'h0, 0, 0));
    // interrupt with all bubbles takes pc_if, accepted via eret_signal
    tbl.push_back(v(0, N,N,N, 3'b111, 1,0,0, I, PC_IF,  4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b111, 1,0,1, N, 0,      4'hF, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    // SYS and interrupt together: SYS first, interrupt next IDLE
    tbl.push_back(v(0, N,S,N, 3'b000, 1,0,0, S, PC_EXE, 4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 1,0,0, N, 0,      4'h0, 0, 0));
    tbl.push_back(v(0, N,N,N, 3'b000, 1,0,0, I, PC_MEM, 4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    // interrupt with MEM bubble takes pc_exe
    tbl.push_back(v(0, N,N,N, 3'b100, 1,0,0, I, PC_EXE, 4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    // ERET at MEM, then reset lands on FLUSH: aborted
    tbl.push_back(v(0, N,N,E, 3'b000, 0,0,0, E, PC_MEM, 4'h0, 1, 1));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,1, N, 0,      4'hF, 1, 1));
    tbl.push_back(v(1, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));
    tbl.push_back(v(0, N,N,N, 3'b000, 0,0,0, N, 0,      4'h0, 0, 0));

    #1;
    foreach (tbl[k]) begin
      drive(tbl[k]);
      step();
      chk($sformatf("v%0d type", k),  32'(exc_type),  32'(tbl[k].x_type));
      chk($sformatf("v%0d pc", k),    exc_pc,         tbl[k].x_pc);
      chk($sformatf("v%0d flush", k), 32'(flush),     32'(tbl[k].x_flush));
      chk($sformatf("v%0d stall", k), 32'(stall_req), 32'(tbl[k].x_stall));
      chk($sformatf("v%0d busy", k),  32'(busy),      32'(tbl[k].x_busy));
    end

    // busy window with DRAIN_CYCLES=4 must be 6 cycles
    drive(v(1, N,N,N, 3'b000, 0,0,0, N, 0, 4'h0, 0, 0));
    step();
    drive(v(0, N,S,N, 3'b000, 0,0,0, N, 0, 4'h0, 0, 0));
    step();
    chk("d4 commit type", 32'(exc_type4), 32'(S));
    drive(v(0, N,N,N, 3'b000, 0,1,0, N, 0, 4'h0, 0, 0));
    nb = 0;
    for (int c = 0; c < 20 && busy4; c++) begin
      nb++;
      step();
      int_signal = 1'b0;
    end
    chk("d4 busy window", 32'(nb), 32'd6);
    chk("d4 idle after", 32'(busy4), 32'd0);

    // reset in the middle of DRAIN
    drive(v(0, N,S,N, 3'b000, 0,0,0, N, 0, 4'h0, 0, 0));
    step();
    drive(v(0, N,N,N, 3'b000, 0,1,0, N, 0, 4'h0, 0, 0));
    step();
    chk("d4 flush", 32'(flush4), 32'hF);
    int_signal = 1'b0;
    step();
    step();
    chk("d4 drain stall", 32'(stall4), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("d4 rst stall", 32'(stall4), 32'd0);
    chk("d4 rst busy", 32'(busy4), 32'd0);
    chk("d4 rst flush", 32'(flush4), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("d4 post %0d flush", c), 32'(flush4), 32'd0);
      chk($sformatf("d4 post %0d busy", c), 32'(busy4), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
